// File: rtl/pattern_source_mc.sv
// Multi-channel PRBS31 / counter / walking-one frame source driving one valid/ready stream.
// Optional error injection is built when PATTERN_SOURCE_MC_ERR_INJ_EN is defined.
`timescale 1ns/1ps
module pattern_source_mc #(
    parameter int          DataBits    = 8,
    parameter int          NumChannels = 4,
    parameter int          MaxLength   = 1024,
    parameter int          CountBits   = 32,
    parameter logic [30:0] LfsrSeed    = 31'h2AAAAAAA,
    localparam int         LenBits     = $clog2(MaxLength + 1),
    localparam int         ChanBits    = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_go,
    input  logic                   cfg_clr,
    input  logic                   cfg_repeat,
    input  logic [2:0]             cfg_pattern,
    input  logic [LenBits-1:0]     cfg_len,
    input  logic [15:0]            cfg_gap,
    input  logic [CountBits-1:0]   cfg_frames,
    input  logic [NumChannels-1:0] cfg_chan_en,
    output logic                   busy,
    output logic                   done,
    output logic [CountBits-1:0]   tx_count,
    output logic [CountBits-1:0]   frame_count,
`ifdef PATTERN_SOURCE_MC_ERR_INJ_EN
    input  logic                   err_inj,
    output logic [15:0]            err_count,
`endif
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [DataBits-1:0]    dout_data,
    output logic                   dout_eof,
    output logic [ChanBits-1:0]    dout_chan
);

    localparam int WordBits = ChanBits + 1 + DataBits;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [30:0] lfsr_adv(input logic [30:0] s);
        logic [30:0] v;
        v = s;
        for (int i = 0; i < DataBits; i++) begin
            v = {v[29:0], v[30] ^ v[27]};
        end
        return v;
    endfunction

    function automatic logic [30:0] seed_of(input int c);
        logic [30:0] v;
        v = LfsrSeed ^ 31'(c);
        return (v == 31'd0) ? 31'd1 : v;
    endfunction

    function automatic logic [LenBits-1:0] eff_len(input logic [LenBits-1:0] l);
        logic [LenBits-1:0] r;
        if (l == {LenBits{1'b0}}) begin
            r = LenBits'(1);
        end else if (l > LenBits'(MaxLength)) begin
            r = LenBits'(MaxLength);
        end else begin
            r = l;
        end
        return r;
    endfunction

    function automatic logic [DataBits-1:0] rotl1(input logic [DataBits-1:0] w);
        return (w << 1) | (w >> (DataBits - 1));
    endfunction

    state_t                state_r, state_nxt_s;
    logic                  start_s, push_s, last_s, frame_end_s, accept_s, mask_any_s, inj_s;
    logic [ChanBits-1:0]   nxt_chan_s, cur_chan_r;
    logic [DataBits-1:0]   gen_data_s;
    logic [WordBits-1:0]   gen_word_s;
    logic [LenBits-1:0]    sh_len_r, word_idx_r;
    logic [2:0]            sh_pat_r;
    logic [15:0]           sh_gap_r, gap_cnt_r;
    logic                  sh_rep_r;
    logic [CountBits-1:0]  frames_gen_r, tx_count_r, frame_count_r;
    logic [30:0]           lfsr_r [NumChannels];
    logic [DataBits-1:0]   cnt_r  [NumChannels];
    logic [DataBits-1:0]   walk_r [NumChannels];
    logic                  out_valid_r, skid_valid_r, busy_r, done_r;
    logic [WordBits-1:0]   out_word_r, skid_word_r;

    // The generator only produces while the skid slot is free, so no word is ever lost.
    assign push_s      = (state_r == ST_ACTIVE) && !skid_valid_r;
    assign last_s      = (word_idx_r == (sh_len_r - LenBits'(1)));
    assign frame_end_s = push_s && last_s;
    assign accept_s    = out_valid_r && dout_ready;
    assign mask_any_s  = |cfg_chan_en;

    // Round-robin pick: first enabled channel above the current one, else the lowest enabled.
    always_comb begin
        logic found_v;
        found_v    = 1'b0;
        nxt_chan_s = cur_chan_r;
        for (int c = 0; c < NumChannels; c++) begin
            if (!found_v && cfg_chan_en[c] && (ChanBits'(c) > cur_chan_r)) begin
                found_v    = 1'b1;
                nxt_chan_s = ChanBits'(c);
            end else begin
                found_v = found_v;
            end
        end
        for (int c = 0; c < NumChannels; c++) begin
            if (!found_v && cfg_chan_en[c]) begin
                found_v    = 1'b1;
                nxt_chan_s = ChanBits'(c);
            end else begin
                found_v = found_v;
            end
        end
    end

    // Pattern word for the current channel.
    always_comb begin
        gen_data_s = {DataBits{1'b0}};
        case (sh_pat_r)
            3'd0:    gen_data_s = lfsr_r[cur_chan_r][DataBits-1:0];
            3'd1:    gen_data_s = cnt_r[cur_chan_r];
            3'd2:    gen_data_s = {DataBits{1'b1}};
            3'd4:    gen_data_s = walk_r[cur_chan_r];
            default: gen_data_s = {DataBits{1'b0}};
        endcase
        gen_word_s = {cur_chan_r, last_s, gen_data_s ^ DataBits'(inj_s)};
    end

    // Next-state logic; start_s marks every edge that opens a new frame.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_go && mask_any_s) begin
                    state_nxt_s = ST_ACTIVE;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!frame_end_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else if ((cfg_frames != {CountBits{1'b0}}) &&
                             ((frames_gen_r + CountBits'(1)) == cfg_frames)) begin
                    state_nxt_s = ST_DONE;
                end else if (!cfg_go) begin
                    state_nxt_s = ST_IDLE;
                end else if (sh_gap_r != 16'd0) begin
                    state_nxt_s = ST_GAP;
                end else if (mask_any_s) begin
                    state_nxt_s = ST_ACTIVE;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r > 16'd1) begin
                    state_nxt_s = ST_GAP;
                end else if (mask_any_s) begin
                    state_nxt_s = ST_ACTIVE;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!cfg_go) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register with registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (cfg_clr) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Frame bookkeeping: shadow config, channel pointer, word index, gap and frame counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_len_r     <= {LenBits{1'b0}};
            sh_pat_r     <= 3'd0;
            sh_gap_r     <= 16'd0;
            sh_rep_r     <= 1'b0;
            cur_chan_r   <= ChanBits'(NumChannels - 1);
            word_idx_r   <= {LenBits{1'b0}};
            gap_cnt_r    <= 16'd0;
            frames_gen_r <= {CountBits{1'b0}};
        end else if (cfg_clr) begin
            sh_len_r     <= {LenBits{1'b0}};
            sh_pat_r     <= 3'd0;
            sh_gap_r     <= 16'd0;
            sh_rep_r     <= 1'b0;
            cur_chan_r   <= ChanBits'(NumChannels - 1);
            word_idx_r   <= {LenBits{1'b0}};
            gap_cnt_r    <= 16'd0;
            frames_gen_r <= {CountBits{1'b0}};
        end else begin
            if (start_s) begin
                sh_len_r   <= eff_len(cfg_len);
                sh_pat_r   <= cfg_pattern;
                sh_gap_r   <= cfg_gap;
                sh_rep_r   <= cfg_repeat;
                cur_chan_r <= nxt_chan_s;
            end
            if (push_s) begin
                word_idx_r <= last_s ? {LenBits{1'b0}} : (word_idx_r + LenBits'(1));
            end
            if (frame_end_s) begin
                gap_cnt_r <= sh_gap_r;
            end else if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r - 16'd1;
            end
            if (state_r == ST_IDLE) begin
                frames_gen_r <= {CountBits{1'b0}};
            end else if (frame_end_s) begin
                frames_gen_r <= frames_gen_r + CountBits'(1);
            end
        end
    end

    // Per-channel pattern state; only the channel owning the pushed word moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NumChannels; c++) begin
                lfsr_r[c] <= seed_of(c);
                cnt_r[c]  <= {DataBits{1'b0}};
                walk_r[c] <= DataBits'(1'b1);
            end
        end else if (cfg_clr) begin
            for (int c = 0; c < NumChannels; c++) begin
                lfsr_r[c] <= seed_of(c);
                cnt_r[c]  <= {DataBits{1'b0}};
                walk_r[c] <= DataBits'(1'b1);
            end
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (push_s && (cur_chan_r == ChanBits'(c))) begin
                    if (last_s && sh_rep_r) begin
                        lfsr_r[c] <= seed_of(c);
                        cnt_r[c]  <= {DataBits{1'b0}};
                        walk_r[c] <= DataBits'(1'b1);
                    end else begin
                        lfsr_r[c] <= lfsr_adv(lfsr_r[c]);
                        cnt_r[c]  <= cnt_r[c] + DataBits'(1);
                        walk_r[c] <= rotl1(walk_r[c]);
                    end
                end
            end
        end
    end

    // Two-entry skid buffer: output register backed by one spill slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_word_r   <= {WordBits{1'b0}};
            skid_valid_r <= 1'b0;
            skid_word_r  <= {WordBits{1'b0}};
        end else if (cfg_clr) begin
            out_valid_r  <= 1'b0;
            out_word_r   <= {WordBits{1'b0}};
            skid_valid_r <= 1'b0;
            skid_word_r  <= {WordBits{1'b0}};
        end else if (!out_valid_r || accept_s) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_word_r   <= skid_word_r;
                skid_valid_r <= 1'b0;
            end else begin
                out_valid_r <= push_s;
                if (push_s) begin
                    out_word_r <= gen_word_s;
                end
            end
        end else if (push_s) begin
            skid_valid_r <= 1'b1;
            skid_word_r  <= gen_word_s;
        end
    end

    // Handshake counters; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_r    <= {CountBits{1'b0}};
            frame_count_r <= {CountBits{1'b0}};
        end else if (cfg_clr) begin
            tx_count_r    <= {CountBits{1'b0}};
            frame_count_r <= {CountBits{1'b0}};
        end else if (accept_s) begin
            tx_count_r <= tx_count_r + CountBits'(1);
            if (out_word_r[DataBits]) begin
                frame_count_r <= frame_count_r + CountBits'(1);
            end
        end
    end

`ifdef PATTERN_SOURCE_MC_ERR_INJ_EN
    logic        armed_r;
    logic [15:0] err_count_r;

    assign inj_s = armed_r && push_s;

    // Injection arm flag and saturating count; pulses while armed are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r     <= 1'b0;
            err_count_r <= 16'd0;
        end else if (cfg_clr) begin
            armed_r     <= 1'b0;
            err_count_r <= 16'd0;
        end else if (inj_s) begin
            armed_r     <= 1'b0;
            err_count_r <= (err_count_r == 16'hFFFF) ? err_count_r : (err_count_r + 16'd1);
        end else if (err_inj) begin
            armed_r <= 1'b1;
        end
    end

    assign err_count = err_count_r;
`else
    assign inj_s = 1'b0;
`endif

    assign busy        = busy_r;
    assign done        = done_r;
    assign tx_count    = tx_count_r;
    assign frame_count = frame_count_r;
    assign dout_valid  = out_valid_r;
    assign dout_data   = out_word_r[DataBits-1:0];
    assign dout_eof    = out_word_r[DataBits];
    assign dout_chan   = out_word_r[WordBits-1 -: ChanBits];

endmodule
